add_seq_ctrl: RTL and testbench

Byte-serial multi-byte add/subtract sequencer that sits around the team's 8-bit ripple-carry adder. It feeds the adder's A, B and carry-in, consumes its SUM and carry-out, and chains the carry across cycles to add or subtract operands of arbitrary byte length, LSB first. It accepts operand bytes through a valid/ready input stream and emits sum bytes through a 2-entry buffered valid/ready output stream with final carry and overflow flags.

---
 rtl/add_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// Byte-serial multi-byte add/subtract sequencer around an external 8-bit adder.
// Operand bytes arrive LSB first; results leave through a 2-entry output FIFO.
module add_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_last,
  input  logic       in_sub,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_carry,
  output logic       out_ovf,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_MID   = 1'b1;

  logic [0:0] state;
  logic       sub_q;
  logic       carry_q;

  logic signed [DATA_W-1:0] a_p1;
  logic signed [DATA_W-1:0] b_p1;
  logic                     first_p1;
  logic                     last_p1;
  logic                     vld_p1;

  logic [DATA_W-1:0] sum_p2   [2];
  logic              last_p2  [2];
  logic              carry_p2 [2];
  logic              ovf_p2   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic accept;
  logic retire;
  logic pop;
  logic can_write;
  logic sub_eff;
  logic cin;

  function automatic logic signed_ovf(input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b,
                                      input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  // A full FIFO may still take a write when its head is popped in the same cycle.
  assign can_write = (count < 2'd2) | ((count == 2'd2) & out_ready);
  assign retire    = vld_p1 & can_write;
  assign in_ready  = ~rst & (~vld_p1 | retire);
  assign accept    = in_valid & in_ready;
  assign sub_eff   = (state == ST_FIRST) ? in_sub : sub_q;
  assign cin       = first_p1 ? sub_q : carry_q;

  // Outputs are gated by their valid flags so they read 0 whenever nothing is held.
  assign add_a     = vld_p1 ? $unsigned(a_p1) : '0;
  assign add_b     = vld_p1 ? $unsigned(b_p1) : '0;
  assign add_cin   = vld_p1 & cin;
  assign out_sum   = out_valid ? sum_p2[rd_ptr] : '0;
  assign out_last  = out_valid & last_p2[rd_ptr];
  assign out_carry = out_valid & carry_p2[rd_ptr];
  assign out_ovf   = out_valid & ovf_p2[rd_ptr];
  assign busy      = (state == ST_MID) | vld_p1 | out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FIRST;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (accept) begin
        state    <= in_last ? ST_FIRST : ST_MID;
        sub_q    <= sub_eff;
        first_p1 <= (state == ST_FIRST);
        last_p1  <= in_last;
        vld_p1   <= 1'b1;
      end else if (retire) begin
        vld_p1   <= 1'b0;
      end
      if (retire) begin
        carry_q <= add_cout;
        wr_ptr  <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, retire} - {1'b0, pop};
    end
  end

  // Stage 1: operand capture, B pre-inverted for subtraction
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1 <= $signed(in_a);
      b_p1 <= $signed(in_b ^ {DATA_W{sub_eff}});
    end
  end

  // Stage 2: result FIFO, flags only meaningful on the word's last byte
  always_ff @(posedge clk) begin
    if (retire) begin
      sum_p2[wr_ptr]   <= add_sum;
      last_p2[wr_ptr]  <= last_p1;
      carry_p2[wr_ptr] <= last_p1 & add_cout;
      ovf_p2[wr_ptr]   <= last_p1 & signed_ovf(a_p1, b_p1, $signed(add_sum));
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: directed scenarios plus random words checked
// against a whole-word arithmetic model through an expected-byte queue.
module tb_add_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic       in_sub;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_carry;
  logic       out_ovf;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_bp = 1'b0;
  logic [10:0] exp_q [$];
  logic [8:0]  adder_full;

  add_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the 8-bit ripple-carry adder
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign add_sum    = adder_full[7:0];
  assign add_cout   = adder_full[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: exact integer add/sub, split into bytes LSB first.
  function automatic void push_word(input int n, input longint a_in, input longint b_in, input bit sub);
    longint m, half, a, b, sa, sb, exact, res;
    bit ovf, carry, last;
    m     = (64'sd1 <<< (8 * n)) - 1;
    half  = 64'sd1 <<< (8 * n - 1);
    a     = a_in & m;
    b     = b_in & m;
    sa    = (a ^ half) - half;
    sb    = (b ^ half) - half;
    exact = sub ? sa - sb : sa + sb;
    ovf   = (exact < -half) || (exact >= half);
    carry = sub ? (a >= b) : ((a + b) > m);
    res   = (sub ? a - b : a + b) & m;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      exp_q.push_back({res[8*i +: 8], last, carry & last, ovf & last});
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("out_byte", 32'({out_sum, out_last, out_carry, out_ovf}), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input logic sub);
    bit done = 1'b0;
    in_a = a; in_b = b; in_last = last; in_sub = sub; in_valid = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom);
    in_last = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input int n, input longint a, input longint b, input bit sub);
    push_word(n, a, b, sub);
    for (int i = 0; i < n; i++)
      send(8'(a >> (8 * i)), 8'(b >> (8 * i)), (i == n - 1),
           (i == 0) ? sub : 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    bit idle = 1'b0;
    rand_bp = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && !idle; c++) begin
      @(negedge clk);
      idle = !busy;
      @(posedge clk); #1;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({in_ready, add_a, add_b, add_cin, out_valid, out_sum,
                out_last, out_carry, out_ovf, busy});
  endfunction

  initial begin
    longint ra, rb, m;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    #2;
    check("reset_outputs", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("idle_after_reset", 32'({out_valid, busy, add_a, add_cin}), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // 0x12FF + 0x0001
    send_word(2, 64'h12FF, 64'h0001, 1'b0);
    drain();

    // 0x05 - 0x07 with one-cycle latency check
    send_word(1, 64'h05, 64'h07, 1'b1);
    check("latency_s1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_out", 32'(out_valid), 32'd1);
    drain();

    send_word(1, 64'h07, 64'h05, 1'b1);
    send_word(1, 64'h7F, 64'h01, 1'b0);
    send_word(1, 64'hFF, 64'h01, 1'b0);
    drain();

    // Back-to-back: carry-free add, then sub whose cin must be 1
    send_word(2, 64'h12FF, 64'h0001, 1'b0);
    send_word(1, 64'h05, 64'h07, 1'b1);
    check("b2b_cin", 32'(add_cin), 32'd1);
    check("b2b_add_b", 32'(add_b), 32'hF8);
    drain();

    // Backpressure: 3 in flight, 4th accepted with the first pop
    out_ready = 1'b0;
    push_word(4, 64'h89ABCDEF, 64'h11223344, 1'b0);
    send(8'hEF, 8'h44, 1'b0, 1'b0);
    send(8'hCD, 8'h33, 1'b0, 1'b1);
    send(8'hAB, 8'h22, 1'b0, 1'b0);
    check("bp_full", 32'(in_ready), 32'd0);
    in_a = 8'h89; in_b = 8'h11; in_last = 1'b1; in_sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("bp_stall", 32'(in_ready), 32'd0);
    check("bp_hold1", 32'({out_valid, out_sum, out_last, out_carry, out_ovf}), 32'({1'b1, exp_q[0]}));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold2", 32'({out_valid, out_sum, out_last, out_carry, out_ovf}), 32'({1'b1, exp_q[0]}));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_with_pop", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset mid-word: first byte of 3 accepted, then asynchronous reset
    out_ready = 1'b0;
    send(8'h55, 8'h66, 1'b0, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midword_reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready_idle", 32'({in_ready, busy, out_valid}), 32'b100);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(1, 64'h01, 64'h01, 1'b0);
    drain();

    // Random words with random backpressure
    for (int w = 0; w < 40; w++) begin
      n = $urandom_range(1, 4);
      m = (64'sd1 <<< (8 * n)) - 1;
      ra = {$urandom, $urandom} & m;
      rb = {$urandom, $urandom} & m;
      if ($urandom_range(0, 7) == 0) ra = m;
      if ($urandom_range(0, 7) == 0) rb = 0;
      rand_bp = 1'($urandom_range(0, 1));
      if (!rand_bp) out_ready = 1'b1;
      send_word(n, ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
